// File: rtl/ldpc_pkg.sv
// Shared QC-LDPC definitions: code geometry defaults, the base-matrix
// shift table (-1 = all-zero circulant) and the syndrome-checker FSM states.
package ldpc_pkg;

  localparam int ZC_D       = 8;
  localparam int NB_D       = 8;
  localparam int MB_D       = 4;
  localparam int MAX_ITER_D = 10;

  localparam int SHIFT [MB_D][NB_D] = '{
    '{ 0,  3, -1,  5,  1, -1,  7,  2},
    '{ 2, -1,  4,  0, -1,  6,  1,  3},
    '{ 5,  1,  7, -1,  3,  2, -1,  0},
    '{ 7,  4,  0,  6,  2, -1,  5, -1}
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_FINISH
  } state_e;

endpackage

// File: rtl/ldpc_row_index.sv
// Combinational row lookup for row block I: (blk, off) -> check row index
// and connected flag. Ports: blk_i, off_i in; row_o, conn_o out.
module ldpc_row_index
  import ldpc_pkg::*;
#(
  parameter int ZC = ZC_D,
  parameter int NB = NB_D,
  parameter int MB = MB_D,
  parameter int I  = 0
) (
  input  logic [$clog2(NB)-1:0]    blk_i,
  input  logic [$clog2(ZC)-1:0]    off_i,
  output logic [$clog2(MB*ZC)-1:0] row_o,
  output logic                     conn_o
);

  localparam int OW = $clog2(ZC);
  localparam int RW = $clog2(MB*ZC);

  int            sh;
  logic [OW:0]   sum;

  always_comb begin
    sh     = SHIFT[I][blk_i];
    conn_o = (sh >= 0);
    sum    = {1'b0, off_i} + (OW+1)'(sh);
    // both addends < ZC, so one subtract wraps the mod
    if (sum >= (OW+1)'(ZC)) begin
      sum = sum - (OW+1)'(ZC);
    end
    row_o = RW'(I*ZC) + RW'(sum);
  end

endmodule

// File: rtl/ldpc_syndrome_check_unit.sv
// Hard-decision syndrome checker with early termination and decoded-word latch.
// In: clk, rst, start, c_valid, C. Out: iter_next, done, pass, iter_count, hd_word, overrun.
module ldpc_syndrome_check_unit
  import ldpc_pkg::*;
#(
  parameter int ZC       = ZC_D,
  parameter int NB       = NB_D,
  parameter int MB       = MB_D,
  parameter int MAX_ITER = MAX_ITER_D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          c_valid,
  input  logic                          C,
  output logic                          iter_next,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  output logic [NB*ZC-1:0]              hd_word,
  output logic                          overrun
);

  localparam int N  = NB*ZC;
  localparam int R  = MB*ZC;
  localparam int CW = $clog2(N);
  localparam int BW = $clog2(NB);
  localparam int OW = $clog2(ZC);
  localparam int RW = $clog2(R);
  localparam int IW = $clog2(MAX_ITER+1);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [R-1:0]    syn_q, syn_d;
  logic [N-1:0]    hd_q, hd_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic            inext_q, inext_d;
  logic            ovr_q, ovr_d;

  logic [BW-1:0]   blk;
  logic [OW-1:0]   off;
  logic [RW-1:0]   row [MB];
  logic [MB-1:0]   conn;

  assign blk = BW'(col_q / CW'(ZC));
  assign off = OW'(col_q % CW'(ZC));

  for (genvar i = 0; i < MB; i++) begin : g_row
    ldpc_row_index #(
      .ZC (ZC),
      .NB (NB),
      .MB (MB),
      .I  (i)
    ) u_row (
      .blk_i  (blk),
      .off_i  (off),
      .row_o  (row[i]),
      .conn_o (conn[i])
    );
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    syn_d   = syn_q;
    hd_d    = hd_q;
    iter_d  = iter_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    inext_d = 1'b0;
    ovr_d   = ovr_q;
    if (start) begin
      // abort/restart; a same-cycle column is dropped
      state_d = S_COLLECT;
      col_d   = '0;
      syn_d   = '0;
      iter_d  = '0;
      pass_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (c_valid && state_q != S_COLLECT) begin
        ovr_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
        end
        S_COLLECT: begin
          if (c_valid) begin
            hd_d[col_q] = C;
            for (int i = 0; i < MB; i++) begin
              if (conn[i] && C) begin
                syn_d[row[i]] = ~syn_d[row[i]];
              end
            end
            col_d = col_q + CW'(1);
            if (col_q == CW'(N-1)) begin
              col_d   = '0;
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          iter_d = iter_q + IW'(1);
          if (syn_q == '0) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else if (iter_q + IW'(1) == IW'(MAX_ITER)) begin
            pass_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            inext_d = 1'b1;
            syn_d   = '0;
            col_d   = '0;
            state_d = S_COLLECT;
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      syn_q   <= '0;
      hd_q    <= '0;
      iter_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      inext_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      syn_q   <= syn_d;
      hd_q    <= hd_d;
      iter_q  <= iter_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      inext_q <= inext_d;
      ovr_q   <= ovr_d;
    end
  end

  assign iter_next  = inext_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign iter_count = iter_q;
  assign hd_word    = hd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ldpc_syndrome_check_unit.sv
// Directed self-checking bench for ldpc_syndrome_check_unit.
// Drives columns #1 after rising edges and samples outputs there too.
module tb_ldpc_syndrome_check_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        c_valid = 1'b0;
  logic        C = 1'b0;
  logic        iter_next;
  logic        done;
  logic        pass;
  logic [3:0]  iter_count;
  logic [63:0] hd_word;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int inext_cnt = 0;
  int base;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iter_next) inext_cnt++;
  end

  ldpc_syndrome_check_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .c_valid    (c_valid),
    .C          (C),
    .iter_next  (iter_next),
    .done       (done),
    .pass       (pass),
    .iter_count (iter_count),
    .hd_word    (hd_word),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // 64 back-to-back columns; column errcol carries C=1
  task automatic frame(input int errcol);
    for (int k = 0; k < 64; k++) begin
      c_valid = 1'b1;
      C = (k == errcol);
      step();
    end
    c_valid = 1'b0;
    C = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_iter_next"}, iter_next, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_iter_count"}, iter_count, 0);
    chk({tag, "_hd_word"}, hd_word, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    rst = 1'b0;
    step();

    // all-zero codeword
    base = inext_cnt;
    pulse_start();
    frame(-1);
    chk("zero_check_done", done, 0);
    step();
    chk("zero_t1_done", done, 0);
    step();
    chk("zero_done", done, 1);
    chk("zero_pass", pass, 1);
    chk("zero_iter", iter_count, 1);
    chk("zero_hd", hd_word, 0);
    step();
    chk("zero_done_pulse", done, 0);
    chk("zero_pass_hold", pass, 1);
    chk("zero_no_inext", inext_cnt - base, 0);

    // single error at column 0, then clean iteration
    pulse_start();
    chk("single_start_pass_clr", pass, 0);
    frame(0);
    chk("single_syndrome", dut.syn_q, 64'h8020_0401);
    chk("single_hd1", hd_word, 64'h1);
    step();
    chk("single_iter_next", iter_next, 1);
    chk("single_iter1", iter_count, 1);
    frame(-1);
    step();
    step();
    chk("single_done", done, 1);
    chk("single_pass", pass, 1);
    chk("single_iter2", iter_count, 2);
    chk("single_hd2", hd_word, 0);

    // persistent error at column 5
    base = inext_cnt;
    pulse_start();
    for (int it = 0; it < 10; it++) begin
      frame(5);
      step();
    end
    step();
    chk("pers_done", done, 1);
    chk("pers_pass", pass, 0);
    chk("pers_iter", iter_count, 10);
    chk("pers_hd", hd_word, 64'h20);
    chk("pers_inext_cnt", inext_cnt - base, 9);
    step();
    chk("pers_iter_hold", iter_count, 10);
    chk("pers_hd_hold", hd_word, 64'h20);

    // reset mid-frame after 30 columns of ones
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      c_valid = 1'b1;
      C = 1'b1;
      step();
    end
    c_valid = 1'b0;
    C = 1'b0;
    chk("mid_hd_pre", hd_word, 64'h3FFF_FFFF);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    step();
    rst = 1'b0;
    step();
    pulse_start();
    frame(-1);
    step();
    step();
    chk("midrst_done", done, 1);
    chk("midrst_pass", pass, 1);
    chk("midrst_iter", iter_count, 1);

    // start during column 20 with same-cycle c_valid
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      c_valid = 1'b1;
      C = 1'b1;
      step();
    end
    start = 1'b1;
    c_valid = 1'b1;
    C = 1'b1;
    step();
    start = 1'b0;
    chk("restart_no_ovr", overrun, 0);
    frame(-1);
    step();
    step();
    chk("restart_done", done, 1);
    chk("restart_pass", pass, 1);
    chk("restart_iter", iter_count, 1);
    chk("restart_hd", hd_word, 0);

    // c_valid while idle
    step();
    c_valid = 1'b1;
    C = 1'b1;
    step();
    c_valid = 1'b0;
    C = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_hd_untouched", hd_word, 0);
    step();
    step();
    chk("ovr_hold", overrun, 1);
    pulse_start();
    chk("ovr_clear", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
